// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types and the round-robin scan helper for the DDR command-port arbiter.
// The command struct is sized by the default address and data widths.
package ddr_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 34;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_MAX_OUT = 16;
    localparam int ID_W        = $clog2(DEF_NUM_REQ);
    localparam int RR_MAX      = 8;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_cmd_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Scan from ptr+1 upward, wrapping modulo num.
    // The last candidate checked is ptr itself.
    function automatic rr_pick_t rr_next(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int                num);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int i = 1; i <= RR_MAX; i++) begin
            cand = (int'(ptr) + i) % num;
            if (i <= num && !pick.found && valid[cand]) begin
                pick.found = 1'b1;
                pick.idx   = 3'(cand);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_id_fifo.sv
// In-order FIFO of granted requester IDs.
// The head entry selects where the next memory response is routed.
module arb_id_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR4 controller command/response port among
// NUM_REQ requesters. Responses are routed back in issue order through an ID FIFO.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic                         mem_cmd_valid,
    input  logic                         mem_cmd_ready,
    output logic                         mem_cmd_we,
    output logic [ADDR_W-1:0]            mem_cmd_addr,
    output logic [DATA_W-1:0]            mem_cmd_wdata,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_W-1:0]            mem_rsp_rdata,
    output logic                         mem_rsp_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_orphan
);
    localparam int REQ_ID_W = $clog2(NUM_REQ);
    localparam int CNT_W    = $clog2(MAX_OUT+1);

    logic [REQ_ID_W-1:0] ptr;
    logic [REQ_ID_W-1:0] grant_id;
    logic [REQ_ID_W-1:0] head_id;
    logic                cr_valid;
    mem_cmd_t            cr;
    rr_pick_t            pick;
    logic                grant;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [CNT_W-1:0]    fifo_count;

    // A new command may be granted only when the command register is free or
    // draining this cycle and the ID FIFO has room for its tag.
    always_comb begin
        pick      = rr_next(RR_MAX'(req_valid), 3'(ptr), NUM_REQ);
        grant     = (!cr_valid || mem_cmd_ready) && !fifo_full && pick.found;
        grant_id  = REQ_ID_W'(pick.idx);
        req_ready = '0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cr_valid <= 1'b0;
            cr       <= '0;
            ptr      <= REQ_ID_W'(NUM_REQ - 1);
        end else if (grant) begin
            cr_valid <= 1'b1;
            cr.we    <= req_we[grant_id];
            cr.addr  <= req_addr[grant_id*ADDR_W +: ADDR_W];
            cr.wdata <= req_wdata[grant_id*DATA_W +: DATA_W];
            ptr      <= grant_id;
        end else if (mem_cmd_ready) begin
            cr_valid <= 1'b0;
        end
    end

    assign mem_cmd_valid = cr_valid;
    assign mem_cmd_we    = cr.we;
    assign mem_cmd_addr  = cr.addr;
    assign mem_cmd_wdata = cr.wdata;

    // With nothing outstanding, any response is an orphan and is swallowed.
    always_comb begin
        rsp_valid     = '0;
        rsp_rdata     = '0;
        mem_rsp_ready = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[head_id] = mem_rsp_valid;
            rsp_rdata          = mem_rsp_rdata;
            mem_rsp_ready      = rsp_ready[head_id];
        end else begin
            mem_rsp_ready = mem_rsp_valid;
        end
    end

    assign fifo_pop = !fifo_empty && mem_rsp_valid && mem_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (fifo_empty && mem_rsp_valid) begin
            err_orphan <= 1'b1;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (REQ_ID_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (grant_id),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head_id)
    );

    assign outstanding = fifo_count;

endmodule
